// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C byte engine: command codes, FSM states, bit phases.
// line_ctl maps (state, phase, data) to the registered {scl_oe, sda_oe} pair driven at phase entry.
package i2c_pkg;

  localparam logic [2:0] CMD_START   = 3'd0;
  localparam logic [2:0] CMD_STOP    = 3'd1;
  localparam logic [2:0] CMD_READ    = 3'd2;
  localparam logic [2:0] CMD_WRITE   = 3'd3;
  localparam logic [2:0] CMD_RESTART = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RESTART, S_STOP, S_BIT, S_ACK
  } state_t;

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  // Returns {scl_oe, sda_oe}; 1 pulls the line low.
  function automatic logic [1:0] line_ctl(input state_t st, input phase_t ph, input logic d);
    logic [1:0] r;
    r = 2'b00;
    case (st)
      S_START: begin
        case (ph)
          PH0:     r = 2'b00;
          PH1:     r = 2'b01;
          default: r = 2'b11;
        endcase
      end
      S_RESTART: begin
        case (ph)
          PH0:     r = 2'b10;
          PH1:     r = 2'b00;
          PH2:     r = 2'b01;
          default: r = 2'b11;
        endcase
      end
      S_STOP: begin
        case (ph)
          PH0:     r = 2'b11;
          PH1:     r = 2'b01;
          default: r = 2'b00;
        endcase
      end
      S_BIT, S_ACK: r = {(ph == PH0) || (ph == PH3), d};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i2c_master_engine_if.sv
// Command handshake and open-drain pad bundle between a sequencer and the I2C engine.
// The engine uses the slave modport; the sequencer/pad side uses master.
interface i2c_master_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic [7:0] tx_byte;
  logic       rx_ack;
  logic [7:0] rx_byte;
  logic       done;
  logic       nack;
  logic       cmd_err;
  logic       busy;
  logic       sda_in;
  logic       scl_in;
  logic       sda_oe;
  logic       scl_oe;

  modport slave (
    input  cmd_valid, cmd, tx_byte, rx_ack, sda_in, scl_in,
    output cmd_ready, rx_byte, done, nack, cmd_err, busy, sda_oe, scl_oe
  );

  modport master (
    output cmd_valid, cmd, tx_byte, rx_ack, sda_in, scl_in,
    input  cmd_ready, rx_byte, done, nack, cmd_err, busy, sda_oe, scl_oe
  );
endinterface

// File: rtl/i2c_phase_timer.sv
// Quarter-bit counter, phase (ph0..ph3) and bit-slot index; load zeroes everything.
// stall freezes the counter in place; phase_end/slot_end mark the advancing cycle.
module i2c_phase_timer
  import i2c_pkg::*;
#(
  parameter int QUARTER = 32,
  parameter int CNT_W   = (QUARTER > 1) ? $clog2(QUARTER) : 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       run,
  input  logic       stall,
  output phase_t     phase,
  output logic [3:0] bit_idx,
  output logic       first_cyc,
  output logic       ph_last,
  output logic       phase_end,
  output logic       slot_end
);

  logic [CNT_W-1:0] cnt;

  assign first_cyc = (cnt == '0);
  assign ph_last   = (cnt == CNT_W'(QUARTER - 1));
  assign phase_end = run && !stall && ph_last;
  assign slot_end  = phase_end && (phase == PH3);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt     <= '0;
      phase   <= PH0;
      bit_idx <= 4'd0;
    end else if (run && !stall) begin
      if (ph_last) begin
        cnt   <= '0;
        phase <= phase_t'(2'(phase + 2'd1));
        if (phase == PH3) bit_idx <= bit_idx + 4'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_master_engine.sv
// One I2C primitive per accepted command (START/RESTART/STOP/WRITE/READ); done pulses 4*QUARTER*N cycles after accept.
// cmd_ready only while idle; define I2C_CLK_STRETCH_EN to hold ph1 while a slave stretches SCL.
module i2c_master_engine
  import i2c_pkg::*;
#(
  parameter int QUARTER = 32,
  parameter int CNT_W   = (QUARTER > 1) ? $clog2(QUARTER) : 1
) (
  input logic               clk,
  input logic               rst,
  i2c_master_engine_if.slave bus
);

  state_t     state, st_nx;
  phase_t     phase, ph_nx;
  logic [3:0] bit_idx, slot_nx;
  logic       first_cyc, ph_last, phase_end, slot_end, stall, accept;
  logic       is_read, ack_bit;
  logic [7:0] txd, shadow;

  assign accept   = bus.cmd_valid && bus.cmd_ready;
  assign bus.busy = ~bus.cmd_ready;

`ifdef I2C_CLK_STRETCH_EN
  assign stall = (state != S_IDLE) && (phase == PH1) && ph_last && !bus.scl_in;
`else
  assign stall = 1'b0;
`endif

  i2c_phase_timer #(.QUARTER(QUARTER), .CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .run       (state != S_IDLE),
    .stall     (stall),
    .phase     (phase),
    .bit_idx   (bit_idx),
    .first_cyc (first_cyc),
    .ph_last   (ph_last),
    .phase_end (phase_end),
    .slot_end  (slot_end)
  );

  // SDA pull for a data slot: slots 0..7 carry the byte, slot 8 is the acknowledge.
  function automatic logic data_bit(input logic rd, input logic [7:0] tx,
                                    input logic ack, input logic [3:0] slot);
    logic [2:0] idx;
    idx = 3'(4'd7 - slot);
    if (slot == 4'd8) return rd & ack;
    return ~rd & ~tx[idx];
  endfunction

  always_comb begin
    ph_nx   = phase_t'(2'(phase + 2'd1));
    slot_nx = (phase == PH3) ? bit_idx + 4'd1 : bit_idx;
    st_nx   = (slot_nx == 4'd8) ? S_ACK : S_BIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.cmd_ready <= 1'b1;
      bus.done      <= 1'b0;
      bus.nack      <= 1'b0;
      bus.cmd_err   <= 1'b0;
      bus.rx_byte   <= 8'h00;
      bus.sda_oe    <= 1'b0;
      bus.scl_oe    <= 1'b0;
      is_read       <= 1'b0;
      ack_bit       <= 1'b0;
      txd           <= 8'h00;
      shadow        <= 8'h00;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            bus.nack      <= 1'b0;
            bus.cmd_err   <= 1'b0;
            bus.cmd_ready <= 1'b0;
            txd           <= bus.tx_byte;
            ack_bit       <= bus.rx_ack;
            is_read       <= (bus.cmd == CMD_READ);
            shadow        <= 8'h00;
            case (bus.cmd)
              CMD_START: begin
                state <= S_START;
                {bus.scl_oe, bus.sda_oe} <= line_ctl(S_START, PH0, 1'b0);
              end
              CMD_RESTART: begin
                state <= S_RESTART;
                {bus.scl_oe, bus.sda_oe} <= line_ctl(S_RESTART, PH0, 1'b0);
              end
              CMD_STOP: begin
                state <= S_STOP;
                {bus.scl_oe, bus.sda_oe} <= line_ctl(S_STOP, PH0, 1'b0);
              end
              CMD_READ, CMD_WRITE: begin
                state <= S_BIT;
                {bus.scl_oe, bus.sda_oe} <= line_ctl(S_BIT, PH0,
                    data_bit(bus.cmd == CMD_READ, bus.tx_byte, bus.rx_ack, 4'd0));
              end
              default: begin
                // Illegal code: no line activity, complete immediately.
                bus.cmd_err   <= 1'b1;
                bus.done      <= 1'b1;
                bus.cmd_ready <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          if (first_cyc && (phase == PH2)) begin
            if ((state == S_BIT) && is_read)  shadow   <= {shadow[6:0], bus.sda_in};
            if ((state == S_ACK) && !is_read) bus.nack <= bus.sda_in;
          end
          if (slot_end && (state != S_BIT)) begin
            // Final slot: SCL stays where the primitive left it; data ops free SDA.
            state         <= S_IDLE;
            bus.done      <= 1'b1;
            bus.cmd_ready <= 1'b1;
            if (state == S_ACK) begin
              bus.sda_oe <= 1'b0;
              if (is_read) bus.rx_byte <= shadow;
            end
          end else if (phase_end) begin
            if ((state == S_BIT) || (state == S_ACK)) begin
              state <= st_nx;
              {bus.scl_oe, bus.sda_oe} <= line_ctl(st_nx, ph_nx,
                  data_bit(is_read, txd, ack_bit, slot_nx));
            end else begin
              {bus.scl_oe, bus.sda_oe} <= line_ctl(state, ph_nx, 1'b0);
            end
          end
        end
      endcase
    end
  end

endmodule
